// File: rtl/hier_seq_pkg.sv
// rtl/hier_seq_pkg.sv - shared types, widths and mask-scan helper for the child sequencer
package hier_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } seq_state_e;

    localparam int TMR_W = 16;

    // Returns {found, idx}: the lowest set bit of mask strictly above
    // 'from', or at/above 'from' when inclusive is set.
    function automatic logic [5:0] next_set_idx(
        input logic [31:0] mask,
        input logic [4:0]  from,
        input logic        inclusive
    );
        logic [5:0] r;
        r = '0;
        // Scanning downward leaves the lowest qualifying bit in r.
        for (int i = 31; i >= 0; i--) begin
            if (mask[i] && ((i > int'(from)) || (inclusive && (i == int'(from))))) begin
                r = {1'b1, 5'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hier_child_sequencer_if.sv
// rtl/hier_child_sequencer_if.sv - sequencer control/child handshake bundle
// Signals: go_i, mask_i, done_i toward the sequencer; start_o, busy_o,
// cur_idx_o, seq_done_o, err_o, err_idx_o from the sequencer.
// slave modport = sequencer side, master modport = controller/children side.
interface hier_child_sequencer_if #(
    parameter int NUM_CHILDREN = 5
);
    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    logic                    go_i;
    logic [NUM_CHILDREN-1:0] mask_i;
    logic [NUM_CHILDREN-1:0] done_i;
    logic [NUM_CHILDREN-1:0] start_o;
    logic                    busy_o;
    logic [IDX_W-1:0]        cur_idx_o;
    logic                    seq_done_o;
    logic                    err_o;
    logic [IDX_W-1:0]        err_idx_o;

    modport slave (
        input  go_i, mask_i, done_i,
        output start_o, busy_o, cur_idx_o, seq_done_o, err_o, err_idx_o
    );

    modport master (
        output go_i, mask_i, done_i,
        input  start_o, busy_o, cur_idx_o, seq_done_o, err_o, err_idx_o
    );
endinterface

// File: rtl/hier_seq_timer.sv
// rtl/hier_seq_timer.sv - per-child WAIT cycle counter with limit detect
// Ports: clk, rst_n (sync active-low), clear_i (zero the count),
// enable_i (count this cycle), limit_i (cycle limit), expired_o
// (high in the enabled cycle where the count equals limit_i-1).
module hier_seq_timer
    import hier_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [TMR_W-1:0] limit_i,
    output logic             expired_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == (limit_i - 1'b1));

endmodule

// File: rtl/hier_child_sequencer.sv
// rtl/hier_child_sequencer.sv - runs enabled child instances one at a time in index order
// Ports: clk, rst_n (sync active-low), bus (hier_child_sequencer_if.slave):
// go_i/mask_i start a run, start_o one-hot start pulse, done_i per-child done,
// busy_o, cur_idx_o, seq_done_o completion pulse, err_o/err_idx_o timeout report.
// Optional macro HIER_SEQ_TIMEOUT_EN adds a per-child WAIT timeout; without it
// WAIT is unbounded and err_o/err_idx_o are tied low.
module hier_child_sequencer
    import hier_seq_pkg::*;
#(
    parameter int NUM_CHILDREN   = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hier_child_sequencer_if.slave  bus
);

    localparam int IDX_W = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1;

    seq_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_CHILDREN-1:0] mask_q, mask_d;
    logic [5:0]              first_hit;
    logic [5:0]              next_hit;

`ifdef HIER_SEQ_TIMEOUT_EN
    logic             err_q, err_d;
    logic [IDX_W-1:0] err_idx_q, err_idx_d;
    logic             tmr_expired;

    // WAIT is only ever entered from ISSUE, so clearing there zeroes the
    // count for the first WAIT cycle of every child.
    hier_seq_timer u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == ISSUE),
        .enable_i  (state_q == WAIT),
        .limit_i   (TMR_W'(TIMEOUT_CYCLES)),
        .expired_o (tmr_expired)
    );
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
`ifdef HIER_SEQ_TIMEOUT_EN
        err_d     = err_q;
        err_idx_d = err_idx_q;
`endif
        // The first child comes from the live mask_i because mask_q is only
        // loaded at the same edge that leaves IDLE.
        first_hit = next_set_idx(32'(bus.mask_i), 5'd0, 1'b1);
        next_hit  = next_set_idx(32'(mask_q), 5'(idx_q), 1'b0);

        case (state_q)
            IDLE: begin
                if (bus.go_i) begin
                    mask_d = bus.mask_i;
`ifdef HIER_SEQ_TIMEOUT_EN
                    err_d  = 1'b0;
`endif
                    if (first_hit[5]) begin
                        idx_d   = IDX_W'(first_hit[4:0]);
                        state_d = ISSUE;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // done wins over a timeout landing in the same cycle.
                if (bus.done_i[idx_q]) begin
                    state_d = NEXT;
                end
`ifdef HIER_SEQ_TIMEOUT_EN
                else if (tmr_expired) begin
                    err_d     = 1'b1;
                    err_idx_d = idx_q;
                    state_d   = NEXT;
                end
`endif
            end
            NEXT: begin
                if (next_hit[5]) begin
                    idx_d   = IDX_W'(next_hit[4:0]);
                    state_d = ISSUE;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            mask_q    <= '0;
`ifdef HIER_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
            err_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            mask_q    <= mask_d;
`ifdef HIER_SEQ_TIMEOUT_EN
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
`endif
        end
    end

    assign bus.start_o    = (state_q == ISSUE) ? (NUM_CHILDREN'(1) << idx_q) : '0;
    assign bus.busy_o     = (state_q != IDLE);
    assign bus.cur_idx_o  = idx_q;
    assign bus.seq_done_o = (state_q == FINISH);
`ifdef HIER_SEQ_TIMEOUT_EN
    assign bus.err_o      = err_q;
    assign bus.err_idx_o  = err_idx_q;
`else
    assign bus.err_o      = 1'b0;
    assign bus.err_idx_o  = '0;
`endif

endmodule

// File: tb/tb_hier_child_sequencer.sv
// tb/tb_hier_child_sequencer.sv - directed self-checking bench for hier_child_sequencer
module tb_hier_child_sequencer;

    localparam int N = 5;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   starts_seen;
    int   dones_seen;
    bit   finished;

    hier_child_sequencer_if #(.NUM_CHILDREN(N)) bus ();

    hier_child_sequencer #(
        .NUM_CHILDREN   (N),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"},    32'(bus.start_o),    32'h0);
        check({tag, "_busy"},     32'(bus.busy_o),     32'h0);
        check({tag, "_cur_idx"},  32'(bus.cur_idx_o),  32'h0);
        check({tag, "_seq_done"}, 32'(bus.seq_done_o), 32'h0);
        check({tag, "_err"},      32'(bus.err_o),      32'h0);
        check({tag, "_err_idx"},  32'(bus.err_idx_o),  32'h0);
    endtask

    initial begin
        int exp_idx [3];
        n_checks = 0;
        n_fail   = 0;
        rst_n      = 1'b0;
        bus.go_i   = 1'b0;
        bus.mask_i = '0;
        bus.done_i = '0;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // single child: go at T0, done visible at T2, seq_done at T4
        bus.go_i = 1'b1; bus.mask_i = 5'b00001;
        tick();                                   // T1
        bus.go_i = 1'b0;
        check("t1_start",  32'(bus.start_o), 32'h01);
        check("t1_busy",   32'(bus.busy_o),  32'h1);
        tick();                                   // T2
        check("t1_start_gone", 32'(bus.start_o), 32'h00);
        bus.done_i = 5'b00001;
        tick();                                   // T3
        bus.done_i = '0;
        check("t1_no_done_yet", 32'(bus.seq_done_o), 32'h0);
        check("t1_busy_t3",     32'(bus.busy_o),     32'h1);
        tick();                                   // T4
        check("t1_seq_done", 32'(bus.seq_done_o), 32'h1);
        check("t1_busy_t4",  32'(bus.busy_o),     32'h1);
        tick();                                   // T5
        check("t1_seq_done_off", 32'(bus.seq_done_o), 32'h0);
        check("t1_idle",         32'(bus.busy_o),     32'h0);
        check("t1_idx_hold",     32'(bus.cur_idx_o),  32'h0);

        // mask 10101, each done two cycles after its start
        exp_idx[0] = 0; exp_idx[1] = 2; exp_idx[2] = 4;
        bus.go_i = 1'b1; bus.mask_i = 5'b10101;
        tick();
        bus.go_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("t2_start_%0d", k), 32'(bus.start_o), 32'h1 << exp_idx[k]);
            check($sformatf("t2_idx_%0d", k),   32'(bus.cur_idx_o), 32'(exp_idx[k]));
            tick();
            check($sformatf("t2_w1_%0d", k), 32'({bus.start_o, bus.seq_done_o}), 32'h0);
            tick();
            bus.done_i = 5'(32'h1 << exp_idx[k]);
            tick();
            bus.done_i = '0;
            check($sformatf("t2_next_%0d", k), 32'({bus.start_o, bus.seq_done_o}), 32'h0);
            tick();
        end
        check("t2_seq_done", 32'(bus.seq_done_o), 32'h1);
        check("t2_idx_last", 32'(bus.cur_idx_o),  32'h4);
        tick();
        check("t2_idle", 32'({bus.busy_o, bus.seq_done_o}), 32'h0);
        check("t2_idx_hold", 32'(bus.cur_idx_o), 32'h4);

        // empty mask: one busy cycle which is the completion pulse
        bus.go_i = 1'b1; bus.mask_i = 5'b00000;
        tick();
        bus.go_i = 1'b0;
        check("t3_busy",     32'(bus.busy_o),     32'h1);
        check("t3_seq_done", 32'(bus.seq_done_o), 32'h1);
        check("t3_start",    32'(bus.start_o),    32'h0);
        tick();
        check("t3_idle", 32'({bus.busy_o, bus.seq_done_o}), 32'h0);

        // go held high across a run; mask change mid-run ignored
        bus.go_i = 1'b1; bus.mask_i = 5'b00110;
        tick();                                   // T1 ISSUE 1
        bus.mask_i = 5'b11111;
        check("t4_start1", 32'(bus.start_o), 32'h02);
        tick();                                   // T2 WAIT
        bus.done_i = 5'b00010;
        tick();                                   // T3 NEXT
        bus.done_i = '0;
        tick();                                   // T4 ISSUE 2
        check("t4_start2", 32'(bus.start_o),   32'h04);
        check("t4_idx2",   32'(bus.cur_idx_o), 32'h2);
        tick();                                   // T5 WAIT
        bus.done_i = 5'b00100;
        tick();                                   // T6 NEXT
        bus.done_i = '0;
        tick();                                   // T7 FINISH
        check("t4_seq_done", 32'(bus.seq_done_o), 32'h1);
        tick();                                   // T8 IDLE, go still high
        check("t4_back_idle", 32'(bus.busy_o), 32'h0);
        tick();                                   // T9 second run, mask 11111
        bus.go_i = 1'b0;
        check("t4_rerun_start", 32'(bus.start_o), 32'h01);
        bus.done_i = 5'b11111;                    // stuck-high dones accepted immediately
        starts_seen = 0;
        dones_seen  = 0;
        finished    = 1'b0;
        for (int c = 0; c < 30 && !finished; c++) begin
            tick();
            if (bus.start_o != '0) starts_seen++;
            if (bus.seq_done_o) begin
                dones_seen++;
                finished = 1'b1;
            end
        end
        bus.done_i = '0;
        check("t4_rerun_finished", 32'(dones_seen),  32'h1);
        check("t4_rerun_starts",   32'(starts_seen), 32'h4);
        tick();
        check("t4_rerun_idle", 32'(bus.busy_o), 32'h0);

        // reset while waiting on child 2
        bus.go_i = 1'b1; bus.mask_i = 5'b10110;
        tick();                                   // ISSUE 1
        bus.go_i = 1'b0;
        tick();                                   // WAIT 1
        bus.done_i = 5'b00010;
        tick();                                   // NEXT
        bus.done_i = '0;
        tick();                                   // ISSUE 2
        tick();                                   // WAIT 2
        check("t5_wait_idx", 32'(bus.cur_idx_o), 32'h2);
        check("t5_wait_busy", 32'(bus.busy_o),   32'h1);
        rst_n = 1'b0;
        tick();
        check_idle_outputs("t5_rst");
        rst_n = 1'b1;
        tick();
        check("t5_after_rst", 32'({bus.start_o, bus.seq_done_o, bus.busy_o}), 32'h0);
        bus.go_i = 1'b1; bus.mask_i = 5'b10110;
        tick();
        bus.go_i = 1'b0;
        check("t5_restart_start", 32'(bus.start_o),   32'h02);
        check("t5_restart_idx",   32'(bus.cur_idx_o), 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef HIER_SEQ_TIMEOUT_EN
        // child 0 hangs: error after 8 WAIT cycles, child 1 still runs
        bus.go_i = 1'b1; bus.mask_i = 5'b00011;
        tick();                                   // T1 ISSUE 0
        bus.go_i = 1'b0;
        for (int c = 0; c < 8; c++) tick();       // T9 last WAIT cycle
        check("t6_no_err_yet", 32'(bus.err_o), 32'h0);
        tick();                                   // T10 NEXT
        check("t6_err",     32'(bus.err_o),     32'h1);
        check("t6_err_idx", 32'(bus.err_idx_o), 32'h0);
        tick();                                   // T11 ISSUE 1
        check("t6_start1", 32'(bus.start_o), 32'h02);
        bus.done_i = 5'b00010;
        tick();                                   // T12 WAIT
        tick();                                   // T13 NEXT
        bus.done_i = '0;
        tick();                                   // T14 FINISH
        check("t6_seq_done", 32'(bus.seq_done_o), 32'h1);
        tick();
        check("t6_err_sticky", 32'(bus.err_o), 32'h1);
        bus.go_i = 1'b1; bus.mask_i = 5'b00001;
        tick();
        bus.go_i = 1'b0;
        check("t6_err_cleared", 32'(bus.err_o), 32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`else
        // without the timeout a silent child holds the run in WAIT
        bus.go_i = 1'b1; bus.mask_i = 5'b00011;
        tick();
        bus.go_i = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("t6_still_waiting", 32'({bus.busy_o, bus.cur_idx_o}), 32'h8);
        check("t6_err_tied",      32'({bus.err_o, bus.err_idx_o}),  32'h0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
